// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types for the two-master memory port arbiter.
//   lock_st_e : bus lock FSM states
//   M_CORE/M_AUX : master indices (core port, loader/debug port)
//   rd_tag_t  : one-deep read tag that routes mem_rdata back to its issuer
package mem_arb_pkg;
  localparam int NUM_M = 2;

  localparam logic M_CORE = 1'b0;
  localparam logic M_AUX  = 1'b1;

  typedef enum logic [1:0] {
    UNLOCKED  = 2'd0,
    LOCKED_M0 = 2'd1,
    LOCKED_M1 = 2'd2
  } lock_st_e;

  typedef struct packed {
    logic valid;
    logic owner;
  } rd_tag_t;
endpackage

// File: rtl/mem_port_arbiter_rr_pick2.sv
// rr_pick2: two-way pick over the eligible request vector.
//   elig : eligible requesters (bit N = master N)
//   last : master granted most recently (used only when RR=1)
//   gnt  : one-hot winner, 0 when nothing is eligible
// RR=1 favours the master not recorded in last; RR=0 lets master 0 win.
module rr_pick2 #(
  parameter bit RR = 1'b1
) (
  input  logic [1:0] elig,
  input  logic       last,
  output logic [1:0] gnt
);
  always_comb begin
    gnt = 2'b00;
    case (elig)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (RR && !last) ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one synchronous memory port between the core
// (master 0) and the loader/debug master (master 1).
//   mN_req/lock/we/addr/wdata/be : master request (held while mN_gnt=0)
//   mN_gnt    : combinational accept, at most one high per cycle
//   mN_rvalid : read data for master N, one cycle after its accepted read
//   mN_rdata  : mem_rdata routed to the issuer, 0 otherwise
//   mem_*     : memory strobe/command, all 0 when no master is granted
//   mem_rdata : memory read data, valid the cycle after a read strobe
// A bounded lock lets one master keep the port (byte-store RMW); a lock
// held for MAX_LOCK cycles is forcibly released and cannot be re-taken
// until that master drops its lock request once.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter bit RR       = 1'b1,
  parameter int MAX_LOCK = 15
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                m0_req,
  input  logic                m0_lock,
  input  logic                m0_we,
  input  logic [ADDR_W-1:0]   m0_addr,
  input  logic [DATA_W-1:0]   m0_wdata,
  input  logic [DATA_W/8-1:0] m0_be,
  output logic                m0_gnt,
  output logic                m0_rvalid,
  output logic [DATA_W-1:0]   m0_rdata,
  input  logic                m1_req,
  input  logic                m1_lock,
  input  logic                m1_we,
  input  logic [ADDR_W-1:0]   m1_addr,
  input  logic [DATA_W-1:0]   m1_wdata,
  input  logic [DATA_W/8-1:0] m1_be,
  output logic                m1_gnt,
  output logic                m1_rvalid,
  output logic [DATA_W-1:0]   m1_rdata,
  output logic                mem_en,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic [DATA_W-1:0]   mem_rdata
);
  localparam int BE_W  = DATA_W / 8;
  localparam int CNT_W = $clog2(MAX_LOCK + 1);

  logic [NUM_M-1:0]             req, lock, we, elig, pick, gnt, rvalid;
  logic [NUM_M-1:0][ADDR_W-1:0] addr;
  logic [NUM_M-1:0][DATA_W-1:0] wdata, rdata;
  logic [NUM_M-1:0][BE_W-1:0]   be;

  lock_st_e         st;
  logic [CNT_W-1:0] lock_cnt;
  logic             last;
  logic [NUM_M-1:0] blk;
  rd_tag_t          tag;
  logic             any, win, own;

  assign req   = {m1_req, m0_req};
  assign lock  = {m1_lock, m0_lock};
  assign we    = {m1_we, m0_we};
  assign addr  = {m1_addr, m0_addr};
  assign wdata = {m1_wdata, m0_wdata};
  assign be    = {m1_be, m0_be};

  // While locked only the owner may be granted, even if it is idle.
  always_comb begin
    elig = '0;
    case (st)
      UNLOCKED:  elig = req;
      LOCKED_M0: elig = req & 2'b01;
      LOCKED_M1: elig = req & 2'b10;
      default:   elig = '0;
    endcase
  end

  rr_pick2 #(.RR(RR)) u_pick (
    .elig (elig),
    .last (last),
    .gnt  (pick)
  );

  // Grants are combinational from req, so gate them during reset to keep
  // every output quiet while resetn is low.
  assign gnt = pick & {NUM_M{resetn}};
  assign any = |gnt;
  assign win = gnt[1];
  assign own = (st == LOCKED_M1);

  assign m0_gnt    = gnt[0];
  assign m1_gnt    = gnt[1];
  assign mem_en    = any;
  assign mem_we    = any & we[win];
  assign mem_addr  = any ? addr[win]  : '0;
  assign mem_wdata = any ? wdata[win] : '0;
  assign mem_be    = any ? be[win]    : '0;

  for (genvar i = 0; i < NUM_M; i++) begin : g_rd
    assign rvalid[i] = tag.valid && (tag.owner == 1'(i));
    assign rdata[i]  = rvalid[i] ? mem_rdata : '0;
  end

  assign m0_rvalid = rvalid[0];
  assign m1_rvalid = rvalid[1];
  assign m0_rdata  = rdata[0];
  assign m1_rdata  = rdata[1];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      st       <= UNLOCKED;
      lock_cnt <= '0;
      last     <= M_AUX;
      blk      <= '0;
      tag      <= '0;
    end else begin
      // Tag is rewritten every cycle: no stall, one read in flight at most.
      tag.valid <= any & ~we[win];
      tag.owner <= win;
      if (any) last <= win;
      for (int i = 0; i < NUM_M; i++)
        if (!lock[i]) blk[i] <= 1'b0;
      case (st)
        UNLOCKED: begin
          if (any && lock[win] && !blk[win]) begin
            st       <= win ? LOCKED_M1 : LOCKED_M0;
            lock_cnt <= CNT_W'(1);
          end
        end
        LOCKED_M0, LOCKED_M1: begin
          if (!lock[own]) begin
            st       <= UNLOCKED;
            lock_cnt <= '0;
          end else if (lock_cnt == CNT_W'(MAX_LOCK)) begin
            // Forced release: hand priority to the other master and
            // block re-acquisition until the owner drops its lock once.
            st       <= UNLOCKED;
            lock_cnt <= '0;
            last     <= own;
            blk[own] <= 1'b1;
          end else begin
            lock_cnt <= lock_cnt + CNT_W'(1);
          end
        end
        default: st <= UNLOCKED;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: two DUTs share one stimulus stream, instance 0 in
// round-robin mode and instance 1 in fixed-priority mode, both with
// MAX_LOCK=4. A behavioural model (owner as an int, pending read as a
// record) predicts every output each cycle; directed sequences add
// explicit checks on top.
module tb_mem_port_arbiter;
  localparam int MAXL = 4;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]            req, lck, we;
  logic [1:0][31:0]      addr, wdata;
  logic [1:0][3:0]       be;

  logic [1:0][1:0]       g_o, rv_o;
  logic [1:0][1:0][31:0] rd_o;
  logic [1:0]            men_o, mwe_o;
  logic [1:0][31:0]      ma_o, mwd_o, mrd;
  logic [1:0][3:0]       mbe_o;

  for (genvar i = 0; i < 2; i++) begin : g_dut
    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RR(i == 0), .MAX_LOCK(MAXL)) u_dut (
      .clk       (clk),
      .resetn    (resetn),
      .m0_req    (req[0]),
      .m0_lock   (lck[0]),
      .m0_we     (we[0]),
      .m0_addr   (addr[0]),
      .m0_wdata  (wdata[0]),
      .m0_be     (be[0]),
      .m0_gnt    (g_o[i][0]),
      .m0_rvalid (rv_o[i][0]),
      .m0_rdata  (rd_o[i][0]),
      .m1_req    (req[1]),
      .m1_lock   (lck[1]),
      .m1_we     (we[1]),
      .m1_addr   (addr[1]),
      .m1_wdata  (wdata[1]),
      .m1_be     (be[1]),
      .m1_gnt    (g_o[i][1]),
      .m1_rvalid (rv_o[i][1]),
      .m1_rdata  (rd_o[i][1]),
      .mem_en    (men_o[i]),
      .mem_we    (mwe_o[i]),
      .mem_addr  (ma_o[i]),
      .mem_wdata (mwd_o[i]),
      .mem_be    (mbe_o[i]),
      .mem_rdata (mrd[i])
    );
  end

  // Synchronous memory stand-in: read data is a fixed function of address.
  function automatic logic [31:0] f(logic [31:0] a);
    return {~a[15:0], a[15:0]};
  endfunction

  always @(posedge clk) mrd <= {f(ma_o[1]), f(ma_o[0])};

  int pass = 0, total = 0;

  task automatic chk(string tag, logic [127:0] got, logic [127:0] exp);
    total++;
    if (got !== exp) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    else pass++;
  endtask

  // Reference model, per instance. m_own = -1 means unlocked.
  int          m_own[2], m_cnt[2], m_last[2], rw[2];
  bit          m_blk[2][2], rp[2];
  logic [31:0] ra[2];
  logic [1:0]  sg;

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_own[i] = -1; m_cnt[i] = 0; m_last[i] = 1; rp[i] = 0; rw[i] = 0; ra[i] = '0;
      m_blk[i][0] = 0; m_blk[i][1] = 0;
    end
  endtask

  function automatic int pick(int i);
    bit e0 = req[0] && (m_own[i] < 0 || m_own[i] == 0);
    bit e1 = req[1] && (m_own[i] < 0 || m_own[i] == 1);
    if (e0 && e1) return (i == 0) ? 1 - m_last[i] : 0;
    if (e0) return 0;
    if (e1) return 1;
    return -1;
  endfunction

  task automatic upd(int i);
    int w = pick(i);
    int o;
    if (w >= 0) begin
      rp[i] = !we[w]; rw[i] = w; ra[i] = addr[w]; m_last[i] = w;
    end else rp[i] = 0;
    if (m_own[i] < 0) begin
      if (w >= 0 && lck[w] && !m_blk[i][w]) begin m_own[i] = w; m_cnt[i] = 1; end
    end else begin
      o = m_own[i];
      if (!lck[o]) m_own[i] = -1;
      else if (m_cnt[i] == MAXL) begin m_own[i] = -1; m_last[i] = o; m_blk[i][o] = 1; end
      else m_cnt[i]++;
    end
    for (int x = 0; x < 2; x++) if (!lck[x]) m_blk[i][x] = 0;
  endtask

  task automatic check_inst(int i);
    string t = (i == 0) ? "rr" : "fix";
    int w;
    logic [1:0]  eg = '0;
    logic [69:0] em = '0;
    logic [65:0] er = '0;
    if (resetn) begin
      w = pick(i);
      if (w >= 0) begin eg[w] = 1'b1; em = {1'b1, we[w], addr[w], wdata[w], be[w]}; end
      if (rp[i]) begin
        er[64 + rw[i]] = 1'b1;
        if (rw[i] == 0) er[31:0] = f(ra[i]); else er[63:32] = f(ra[i]);
      end
    end
    chk({t, "_gnt"}, 128'(g_o[i]), 128'(eg));
    chk({t, "_mem"}, 128'({men_o[i], mwe_o[i], ma_o[i], mwd_o[i], mbe_o[i]}), 128'(em));
    chk({t, "_rd"}, 128'({rv_o[i], rd_o[i][1], rd_o[i][0]}), 128'(er));
  endtask

  // settle: mid-cycle compare; adv: clock edge, model step, move off edge.
  task automatic settle();
    @(negedge clk);
    check_inst(0);
    check_inst(1);
    sg = g_o[0];
  endtask

  task automatic adv();
    @(posedge clk);
    if (resetn) begin upd(0); upd(1); end
    #1;
  endtask

  task automatic clr_in();
    req = '0; lck = '0; we = '0; addr = '0; wdata = '0; be = '0;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    model_reset();
    settle();
    adv();
    resetn = 1'b1;
  endtask

  task automatic rand_in();
    for (int x = 0; x < 2; x++) begin
      if (!(req[x] && !sg[x])) begin
        req[x]   = ($urandom_range(0, 99) < 65);
        we[x]    = 1'($urandom_range(0, 1));
        addr[x]  = 32'($urandom_range(0, 255)) << 2;
        wdata[x] = $urandom;
        be[x]    = 4'($urandom_range(0, 15));
        if ($urandom_range(0, 9) < 2) lck[x] = ~lck[x];
      end
    end
  endtask

  initial begin
    clr_in();
    model_reset();
    sg = '0;
    @(posedge clk); #1;
    req = 2'b11; addr[0] = 32'h10; addr[1] = 32'h20;
    do_reset();

    // Both read after reset: m0 first, then m1, data routed to issuer.
    settle();
    chk("t1_m0_gnt", 128'(g_o[0][0]), 128'(1));
    chk("t1_addr", 128'(ma_o[0]), 128'h10);
    adv();
    req[0] = 1'b0;
    settle();
    chk("t1_m1_gnt", 128'(g_o[0][1]), 128'(1));
    chk("t1_m0_rv", 128'(rv_o[0][0]), 128'(1));
    chk("t1_m0_rd", 128'(rd_o[0][0]), 128'(f(32'h10)));
    adv();
    req[1] = 1'b0;
    settle();
    chk("t1_m1_rv", 128'(rv_o[0][1]), 128'(1));
    chk("t1_m1_rd", 128'(rd_o[0][1]), 128'(f(32'h20)));
    adv();

    // Byte-lane write: no read data follows.
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h4; wdata[0] = 32'hDEADBEEF; be[0] = 4'b0100;
    settle();
    chk("t2_we", 128'(mwe_o[0]), 128'(1));
    chk("t2_be", 128'(mbe_o[0]), 128'(4'b0100));
    chk("t2_wd", 128'(mwd_o[0]), 128'hDEADBEEF);
    adv();
    clr_in();
    settle();
    chk("t2_no_rv", 128'(rv_o[0]), 128'(0));
    adv();

    // Locked read-modify-write by m0 while m1 keeps requesting.
    do_reset();
    req = 2'b11; lck[0] = 1'b1; addr[0] = 32'h8; addr[1] = 32'h20;
    settle();
    chk("t3_acq", 128'(g_o[0]), 128'(2'b01));
    adv();
    req[0] = 1'b0;
    settle();
    chk("t3_idle_lock", 128'(g_o[0][1]), 128'(0));
    adv();
    req[0] = 1'b1; we[0] = 1'b1; wdata[0] = 32'h0000AB00; be[0] = 4'b0010;
    settle();
    chk("t3_wr", 128'(g_o[0]), 128'(2'b01));
    adv();
    req[0] = 1'b0; lck[0] = 1'b0;
    settle();
    chk("t3_unlock_cyc", 128'(g_o[0][1]), 128'(0));
    adv();
    settle();
    chk("t3_m1_after", 128'(g_o[0][1]), 128'(1));
    adv();
    clr_in();

    // Lock held forever: forced release after MAX_LOCK cycles.
    do_reset();
    req = 2'b11; lck[0] = 1'b1; addr[0] = 32'h40; addr[1] = 32'h44;
    settle();
    chk("t4_acq", 128'(g_o[0]), 128'(2'b01));
    adv();
    for (int k = 0; k < MAXL; k++) begin
      settle();
      chk("t4_held", 128'(g_o[0]), 128'(2'b01));
      adv();
    end
    settle();
    chk("t4_release", 128'(g_o[0]), 128'(2'b10));
    adv();
    settle();
    chk("t4_m0_plain", 128'(g_o[0]), 128'(2'b01));
    adv();
    settle();
    chk("t4_blk", 128'(g_o[0]), 128'(2'b10));
    adv();
    clr_in();

    // Fixed priority: m1 starves while m0 requests every cycle.
    do_reset();
    req = 2'b11;
    for (int k = 0; k < 20; k++) begin
      addr[0] = 32'($urandom_range(0, 255)) << 2;
      settle();
      chk("t5_fix", 128'(g_o[1]), 128'(2'b01));
      adv();
    end
    clr_in();

    // Reset with an m1 read in flight drops the rvalid.
    do_reset();
    req[1] = 1'b1; addr[1] = 32'h20;
    settle();
    adv();
    resetn = 1'b0;
    model_reset();
    #1;
    chk("t6_rv", 128'(rv_o[0][1]), 128'(0));
    chk("t6_outs", 128'({g_o[0], rv_o[0], rd_o[0], men_o[0], ma_o[0], mwe_o[0], mbe_o[0]}), 128'(0));
    settle();
    adv();
    resetn = 1'b1;
    req = 2'b11; addr[0] = 32'h10;
    settle();
    chk("t6_m0_first", 128'(g_o[0]), 128'(2'b01));
    adv();
    clr_in();

    // Random traffic with occasional resets.
    for (int k = 0; k < 800; k++) begin
      if ($urandom_range(0, 199) == 0) do_reset();
      rand_in();
      settle();
      adv();
    end

    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single synchronous memory port between two masters. Master 0 is the multicycle core's load/store/fetch port. Master 1 is a loader/debug master that preloads and inspects memory. The block does per-cycle round-robin (or fixed-priority) grant with zero-latency acceptance and tags each read so its data returns only to the issuer one cycle later. It also provides a bounded bus lock, so the core's byte-store read-modify-write (read word, merge byte, write word) cannot be split by the other master.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width; byte enables are DATA_W/8 bits
- RR, 1, 1 = round-robin, 0 = fixed priority with master 0 winning
- MAX_LOCK, 15, maximum consecutive cycles one owner may hold the lock; must be at least 1
- clk  in  1  single clock; all state on rising edge
- resetn  in  1  asynchronous, active-low reset
- mN_req  in  1  master N (N = 0, 1) requests an access
- mN_lock  in  1  request or keep bus ownership
- mN_we  in  1  1 = write, 0 = read
- mN_addr  in  ADDR_W  byte address
- mN_wdata  in  DATA_W  write data
- mN_be  in  DATA_W/8  byte enables, applied to writes
- mN_gnt  out  1  access accepted this cycle (combinational)
- mN_rvalid  out  1  read data valid for master N
- mN_rdata  out  DATA_W  read data; 0 when mN_rvalid is 0
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_be  out  DATA_W/8  memory byte enables
- mem_rdata  in  DATA_W  memory read data, valid the cycle after mem_en=1 and mem_we=0

## Operation
- An access transfers on a rising edge where mN_req=1 and mN_gnt=1. A requester whose mN_gnt=0 holds all of its request signals stable.
- At most one mN_gnt is high per cycle.
- The granted master's we, addr, wdata and be drive the mem_* outputs combinationally, with mem_en=1.
- When no master is granted: mem_en=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0.
- Eligibility: in UNLOCKED, every requesting master is eligible; in LOCKED_Mx, only master x is eligible. The non-owner gets no grant during a lock, even when the owner is idle.
- Pick among eligible requesters:
  - RR=1: the master not recorded in `last` wins. `last` updates to the granted master on every grant.
  - RR=0: master 0 wins.
- Read tracking: a registered tag (valid bit and owner) captures each accepted read. Next cycle the block drives that owner's rvalid=1 and rdata=mem_rdata; the other master's rdata stays 0. Writes produce no rvalid.
- Lock FSM states are UNLOCKED, LOCKED_M0 and LOCKED_M1.
  - UNLOCKED → LOCKED_Mx when master x is granted with mx_lock=1 and blk_x=0. On entry, lock_cnt ← 1.
  - In LOCKED_Mx while mx_lock=1, lock_cnt increments every cycle, whether or not master x requests.
  - LOCKED_Mx → UNLOCKED when mx_lock=0 is sampled.
  - Forced release: LOCKED_Mx → UNLOCKED at the edge where lock_cnt == MAX_LOCK. That edge also sets `last` ← x and blk_x ← 1.
  - blk_x=1 makes master x's lock ignored for acquisition; a later grant to master x is then a plain access. blk_x clears on the edge where mx_lock=0 is sampled.
- lock_cnt is $clog2(MAX_LOCK+1) bits wide and never wraps.
- Reset (asynchronous, from any state, including with a read in flight):
  - state=UNLOCKED, lock_cnt=0, last=1 (so master 0 wins first), blk_0=blk_1=0.
  - Read tag cleared; any pending rvalid is dropped and never delivered.
  - Outputs: all mN_gnt=0, mN_rvalid=0, mN_rdata=0, and every mem_* output 0.
- Both masters requesting with lock in UNLOCKED: the normal pick applies, and only the winner acquires the lock.

## Timing
- Grant latency is 0 cycles: gnt rises in the same cycle as req when the master is eligible.
- Read data arrives exactly 1 cycle after the accepting edge. Write completes at the accepting edge.
- Throughput is one access per cycle, including back-to-back accesses that alternate masters. The read tag is overwritten each cycle with no stall.
- Lock hold is at most MAX_LOCK cycles, so the non-owner waits at most MAX_LOCK+1 cycles for a grant.

## Structure
- Package mem_arb_pkg holds: the lock-state enum (UNLOCKED, LOCKED_M0, LOCKED_M1), the master index constants M_CORE=0 and M_AUX=1, and the read-tag struct (valid, owner).
- One sub-module, rr_pick2: the two-way priority pick from the eligible request vector and the `last` pointer, with the RR/fixed selection as its parameter. Mux, lock FSM and read tag stay in the top module.

## Test plan
- Reset with m0 and m1 requesting reads at 0x10 and 0x20 → first cycle m0_gnt=1 and mem_addr=0x10; next cycle m1_gnt=1 and m0_rvalid=1 carrying the mem_rdata for 0x10; the cycle after, m1_rvalid=1.
- m0 write (addr 0x4, wdata 0xDEADBEEF, be 4'b0100) → mem_we=1, mem_be=4'b0100 in the grant cycle; no rvalid on either master.
- m0 locked byte store (lock=1: read 0x8, then write 0x8) while m1 requests continuously → m1_gnt=0 until the edge where m0_lock=0 is sampled, then m1 is granted the following cycle.
- MAX_LOCK=4, m0 holds lock=1 indefinitely while m1 requests → forced release after 4 locked cycles; m1 granted next; m0's lock ignored until m0_lock drops once.
- RR=0 with both masters requesting every cycle → m1 never granted; m0_gnt=1 every cycle.
- resetn pulsed low in the cycle after an accepted m1 read → m1_rvalid=0; all outputs 0 while in reset; after release, state=UNLOCKED and m0 wins first contention.
